// File: rtl/operand_accumulator_if.sv
// Handshake bundle for operand_accumulator: job start, operand stream in, result out.
// master = job/operand producer and result consumer, slave = the accumulator.
interface operand_accumulator_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    localparam int RW = WIDTH + CNT_W;

    logic             start;
    logic [CNT_W-1:0] count;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [RW-1:0]    result;
    logic             busy;

    modport master (
        output start, count, in_valid, in_data, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  start, count, in_valid, in_data, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/operand_accumulator.sv
// Sums a job of `count` unsigned operands into a non-wrapping WIDTH+CNT_W result.
// Latency: out_valid rises one cycle after the last accepted operand.
// Backpressure: in_ready only in ACC; result held in DONE until out_ready.
module operand_accumulator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    operand_accumulator_if.slave bus
);
    localparam int RW = WIDTH + CNT_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [RW-1:0]    acc;
    logic [CNT_W-1:0] remaining;
    logic             in_rdy_q;
    logic             out_vld_q;
    logic             busy_q;

    // Handshake flags are registered alongside the state so no input reaches an output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc    <= '0;
                        busy_q <= 1'b1;
                        if (bus.count != '0) begin
                            remaining <= bus.count;
                            state     <= ACC;
                            in_rdy_q  <= 1'b1;
                        end else begin
                            state     <= DONE;
                            out_vld_q <= 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (bus.in_valid && in_rdy_q) begin
                        acc       <= acc + {{CNT_W{1'b0}}, bus.in_data};
                        remaining <= remaining - {{(CNT_W-1){1'b0}}, 1'b1};
                        if (remaining == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            state     <= DONE;
                            in_rdy_q  <= 1'b0;
                            out_vld_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state     <= IDLE;
                        out_vld_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_rdy_q  <= 1'b0;
                    out_vld_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_rdy_q;
    assign bus.out_valid = out_vld_q;
    assign bus.busy      = busy_q;
    assign bus.result    = acc;
endmodule
